// File: rtl/snake_head_stepper_pkg.sv
// Shared types and defaults for the snake head stepper: direction and FSM state
// enums, default grid size, and the direction priority helper.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD
    } state_t;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    // Several flags may be high at once; vertical moves take precedence.
    function automatic dir_t pick_dir(
        input logic up,
        input logic down,
        input logic left,
        input logic right
    );
        dir_t dir;
        dir = DIR_NONE;
        if (up) begin
            dir = DIR_UP;
        end else if (down) begin
            dir = DIR_DOWN;
        end else if (left) begin
            dir = DIR_LEFT;
        end else if (right) begin
            dir = DIR_RIGHT;
        end
        return dir;
    endfunction

endpackage

// File: rtl/snake_head_stepper_move_tick_gen.sv
// Move pacing counter: emits a one-cycle tick every TICK_CYCLES enabled cycles,
// and sits at zero whenever it is disabled or cleared.
module move_tick_gen #(
    parameter int TICK_CYCLES = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = 1'b0;
        count_d = count_q;
        if (!enable || clear) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
            tick    = 1'b1;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: turns held direction flags into paced grid moves with wall
// detection. Define WRAP_EN to wrap at the grid edges instead of dying.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 12500000,
    parameter int GRID_W      = GRID_W_DEF,
    parameter int GRID_H      = GRID_H_DEF,
    parameter int X_W         = 5,
    parameter int Y_W         = 5,
    parameter int START_X     = 16,
    parameter int START_Y     = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stage,
    input  logic           Up,
    input  logic           Down,
    input  logic           Right,
    input  logic           Left,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic           step,
    output logic           collision,
    output logic           running
);

    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

    state_t         state_q, state_d;
    logic [X_W-1:0] head_x_q, head_x_d;
    logic [Y_W-1:0] head_y_q, head_y_d;
    logic           step_q, step_d;
    logic           tick;
    logic           any_dir;
    logic           tick_enable;
    logic           tick_clear;

    assign any_dir     = Up | Down | Left | Right;
    assign tick_enable = (state_q == S_RUN);
    // Clearing on a falling stage also swallows a tick landing on that cycle.
    assign tick_clear  = ~stage;

    move_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(tick_enable),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        step_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                head_x_d = X_START;
                head_y_d = Y_START;
                if (stage && any_dir) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stage) begin
                    state_d  = S_IDLE;
                    head_x_d = X_START;
                    head_y_d = Y_START;
                end else if (tick) begin
                    // Edge checks happen before any arithmetic so nothing underflows.
                    case (pick_dir(Up, Down, Left, Right))
                        DIR_UP: begin
                            if (head_y_q == '0) begin
`ifdef WRAP_EN
                                head_y_d = Y_MAX;
                                step_d   = 1'b1;
`else
                                state_d  = S_DEAD;
`endif
                            end else begin
                                head_y_d = head_y_q - 1'b1;
                                step_d   = 1'b1;
                            end
                        end
                        DIR_DOWN: begin
                            if (head_y_q >= Y_MAX) begin
`ifdef WRAP_EN
                                head_y_d = '0;
                                step_d   = 1'b1;
`else
                                state_d  = S_DEAD;
`endif
                            end else begin
                                head_y_d = head_y_q + 1'b1;
                                step_d   = 1'b1;
                            end
                        end
                        DIR_LEFT: begin
                            if (head_x_q == '0) begin
`ifdef WRAP_EN
                                head_x_d = X_MAX;
                                step_d   = 1'b1;
`else
                                state_d  = S_DEAD;
`endif
                            end else begin
                                head_x_d = head_x_q - 1'b1;
                                step_d   = 1'b1;
                            end
                        end
                        DIR_RIGHT: begin
                            if (head_x_q >= X_MAX) begin
`ifdef WRAP_EN
                                head_x_d = '0;
                                step_d   = 1'b1;
`else
                                state_d  = S_DEAD;
`endif
                            end else begin
                                head_x_d = head_x_q + 1'b1;
                                step_d   = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_DEAD: begin
                if (!stage) begin
                    state_d  = S_IDLE;
                    head_x_d = X_START;
                    head_y_d = Y_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            head_x_q <= X_START;
            head_y_q <= Y_START;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            step_q   <= step_d;
        end
    end

    assign head_x  = head_x_q;
    assign head_y  = head_y_q;
    assign step    = step_q;
    assign running = (state_q == S_RUN);
`ifdef WRAP_EN
    assign collision = 1'b0;
`else
    assign collision = (state_q == S_DEAD);
`endif

endmodule

// File: tb/tb_snake_head_stepper.sv
// Randomized and directed bench for snake_head_stepper on a small 8x6 grid,
// compared cycle by cycle against a coordinate-level reference model.
module tb_snake_head_stepper;

    localparam int TICK = 4;
    localparam int GW   = 8;
    localparam int GH   = 6;
    localparam int SX   = 4;
    localparam int SY   = 3;

    logic       clk;
    logic       reset;
    logic       stage;
    logic       up, down, right, left;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic       step;
    logic       collision;
    logic       running;

    int check_count;
    int fail_count;

    // Model: mode 0 = waiting, 1 = moving, 2 = crashed; phase counts cycles since moving began.
    int m_mode;
    int m_phase;
    int m_x;
    int m_y;
    int m_step;

    snake_head_stepper #(
        .TICK_CYCLES(TICK),
        .GRID_W     (GW),
        .GRID_H     (GH),
        .X_W        (3),
        .Y_W        (3),
        .START_X    (SX),
        .START_Y    (SY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stage    (stage),
        .Up       (up),
        .Down     (down),
        .Right    (right),
        .Left     (left),
        .head_x   (head_x),
        .head_y   (head_y),
        .step     (step),
        .collision(collision),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        int exp_coll;
`ifdef WRAP_EN
        exp_coll = 0;
`else
        exp_coll = (m_mode == 2) ? 1 : 0;
`endif
        checkOutput({tag, ".head_x"}, int'(head_x), m_x);
        checkOutput({tag, ".head_y"}, int'(head_y), m_y);
        checkOutput({tag, ".step"}, int'(step), m_step);
        checkOutput({tag, ".running"}, int'(running), (m_mode == 1) ? 1 : 0);
        checkOutput({tag, ".collision"}, int'(collision), exp_coll);
    endtask

    task automatic modelReset();
        m_mode  = 0;
        m_phase = 0;
        m_x     = SX;
        m_y     = SY;
        m_step  = 0;
    endtask

    // Advance the model across one rising edge using the inputs held at that edge.
    task automatic modelEdge();
        int  dx, dy, nx, ny;
        bit  ticked;
        m_step = 0;
        if (!reset) begin
            modelReset();
            return;
        end
        case (m_mode)
            0: begin
                m_x = SX;
                m_y = SY;
                if (stage && (up || down || left || right)) begin
                    m_mode  = 1;
                    m_phase = 0;
                end
            end
            1: begin
                if (!stage) begin
                    m_mode = 0;
                    m_x    = SX;
                    m_y    = SY;
                end else begin
                    ticked  = (m_phase == TICK - 1);
                    m_phase = (m_phase + 1) % TICK;
                    if (ticked) begin
                        dx = 0;
                        dy = 0;
                        if (up)         dy = -1;
                        else if (down)  dy = 1;
                        else if (left)  dx = -1;
                        else if (right) dx = 1;
                        if (dx != 0 || dy != 0) begin
                            nx = m_x + dx;
                            ny = m_y + dy;
                            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
`ifdef WRAP_EN
                                m_x    = (nx + GW) % GW;
                                m_y    = (ny + GH) % GH;
                                m_step = 1;
`else
                                m_mode = 2;
`endif
                            end else begin
                                m_x    = nx;
                                m_y    = ny;
                                m_step = 1;
                            end
                        end
                    end
                end
            end
            default: begin
                if (!stage) begin
                    m_mode = 0;
                    m_x    = SX;
                    m_y    = SY;
                end
            end
        endcase
    endtask

    task automatic runCycle(input string tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic applyStimulus(input logic st, input logic u, input logic d,
                                 input logic l, input logic r, input int cycles,
                                 input string tag);
        stage = st;
        up    = u;
        down  = d;
        left  = l;
        right = r;
        for (int i = 0; i < cycles; i++) begin
            runCycle(tag);
        end
    endtask

    // Pull reset low between edges and expect the outputs to drop straight away.
    task automatic resetMidCycle();
        @(posedge clk);
        modelEdge();
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("mid_reset");
        @(negedge clk);
        checkAll("mid_reset_hold");
        reset = 1'b1;
    endtask

    initial begin
        int r;
        check_count = 0;
        fail_count  = 0;
        reset = 1'b0;
        stage = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll("reset");
        reset = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20, "right_run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, "stage_low");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5, "up_left_prio");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, "no_flags");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6, "down");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, "pre_reset");
        resetMidCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30, "left_edge");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stage_low2");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20, "up_edge");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stage_low3");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                stage = ~stage;
            end
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                up    = (r == 1);
                down  = (r == 2);
                left  = (r == 3);
                right = (r == 4);
                if (r >= 5) begin
                    {up, down, left, right} = 4'($urandom_range(0, 15));
                end
            end
            if (i == 400) begin
                resetMidCycle();
            end else begin
                runCycle("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
